move_cmd_scheduler: RTL and testbench
=====================================

// Module: move_cmd_scheduler
// PURPOSE
//  Sequences block-position updates for the VGA move-block game. Collects debounced key
//  pulses (one-cycle negedge flags from key_filter) as direction commands in a small FIFO.
//  Applies at most one command per video frame, at vertical-sync start, with screen-edge
//  clamping. Drives block_x/block_y to the pixel/move logic, so the drawn block never
//  changes mid-frame.
// PARAMETERS
//  H_ACTIVE    800  visible pixels per line (800x600 @ 40 MHz pixel clock)
//  V_ACTIVE    600  visible lines per frame
//  BLK_W       40   block width, pixels
//  BLK_H       40   block height, lines
//  STEP        20   pixels moved per applied command
//  X0          380  reset/home x (top-left corner)
//  Y0          280  reset/home y
//  FIFO_DEPTH  4    command queue depth (power of 2)
//  VS_ACT      1    active level of vga_vs
// PORTS
//  clk        in   1   system clock (CLOCK_50); the only clock
//  rst_n      in   1   asynchronous active-low reset (driven from PLL locked)
//  key_up     in   1   one-cycle pulse: move up (y - STEP)
//  key_down   in   1   one-cycle pulse: move down (y + STEP)
//  key_left   in   1   one-cycle pulse: move left (x - STEP)
//  key_right  in   1   one-cycle pulse: move right (x + STEP)
//  vga_vs     in   1   vertical sync from the pixel domain; level, asynchronous to clk
//  block_x    out  10  current block top-left x
//  block_y    out  10  current block top-left y
//  pos_valid  out  1   one-cycle pulse when block_x/block_y change
//  cmd_drop   out  1   one-cycle pulse when a command is lost (FIFO full)
//  fifo_level out  3   occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - block_x=X0, block_y=Y0; pos_valid=0, cmd_drop=0, fifo_level=0.
//   - FIFO emptied, FSM to IDLE, synchroniser flops cleared.
//  Command capture (every clk):
//   - cmd = {up,down,left,right}. Opposite pairs cancel: up&down clears both; left&right likewise.
//   - Simultaneous orthogonal keys form one diagonal command.
//   - cmd==0 after cancel -> nothing pushed.
//   - Push when cmd!=0 and not full.
//   - Full and no pop this cycle -> cmd discarded; cmd_drop=1 the next cycle.
//   - Push and pop in the same cycle while full -> both succeed; no drop.
//  Frame sync:
//   - vga_vs passes a 2-flop synchroniser plus one edge register.
//   - frame_start = synced vs transitions inactive->VS_ACT; it is 1 cycle wide.
//  FSM (IDLE, CALC):
//   - IDLE: frame_start and FIFO non-empty -> pop head into cmd_r, go to CALC.
//   - IDLE: frame_start with FIFO empty -> stay in IDLE; no output change.
//   - CALC: register the clamped new position, pulse pos_valid for 1 cycle, return to IDLE.
//   - CALC always lasts exactly 1 cycle.
//   - Latency: block_x/block_y/pos_valid update 2 clk cycles after the frame_start cycle.
//   - One command per frame maximum. Remaining queued commands wait for later frames.
//  Arithmetic (11-bit signed intermediates):
//   - x' = left ? max(x-STEP, 0) : right ? min(x+STEP, H_ACTIVE-BLK_W) : x.
//   - y' = up ? max(y-STEP, 0) : down ? min(y+STEP, V_ACTIVE-BLK_H) : y.
//   - Block at its limit with a further move toward the limit -> position unchanged.
//     pos_valid still pulses (command consumed).
//  FIFO: pointers wrap modulo FIFO_DEPTH; fifo_level is exact and never exceeds FIFO_DEPTH.
//  Reset mid-operation (including during CALC): outputs return to reset values immediately;
//  the queued command is lost.
// STRUCTURE
//  Shared package vga_game_pkg:
//   - H_ACTIVE/V_ACTIVE constants.
//   - Command bit indices CMD_UP=3, CMD_DN=2, CMD_LF=1, CMD_RT=0.
//   - typedef cmd_t (4-bit).
//   - FSM state encoding.
//  Sub-module cmd_fifo:
//   - Parameterised width/depth synchronous FIFO with push/pop/full/empty/level.
//   - Same clk/rst_n as this block.
//  Top level holds the synchroniser, cancel/encode logic, FSM and clamp datapath.
// TESTING
//  1. Reset, then a right pulse, then vs rising -> x=400, y=280, pos_valid exactly 2 clks after frame_start.
//  2. Three left pulses, then three frames -> x=360, 340, 320, one step per frame; fifo_level 3->2->1->0.
//  3. Block at x=760, right pulse, frame -> x stays 760, pos_valid=1.
//     Block at y=0, up pulse -> y stays 0.
//  4. up and down in the same cycle -> nothing queued, fifo_level stays 0.
//     up and left in the same cycle -> one entry; next frame x=360, y=260.
//  5. Six pulses with no frame -> fifo_level=4, cmd_drop pulses twice.
//     Push coinciding with a pop while full -> no drop.
//  6. rst_n low during CALC -> x=380, y=280, FIFO empty; no pos_valid after release until a new command and frame.

Source files
------------

// File: rtl/vga_game_pkg.sv
// Shared definitions for the VGA move-block game.
//   H_ACTIVE/V_ACTIVE : visible raster size (800x600)
//   CMD_*             : bit positions inside a direction command
//   cmd_t             : 4-bit direction command {up, down, left, right}
//   sched_state_t     : move scheduler FSM encoding
//   step_clamp()      : one-axis move by a step, clamped to [0, lim]
package vga_game_pkg;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;

    localparam int CMD_UP = 3;
    localparam int CMD_DN = 2;
    localparam int CMD_LF = 1;
    localparam int CMD_RT = 0;

    typedef logic [3:0] cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } sched_state_t;

    // Signed 11-bit intermediate so that a decrement below zero is seen as
    // negative instead of wrapping to a large unsigned value.
    function automatic logic [9:0] step_clamp(
        input logic [9:0]  pos,
        input logic        dec,
        input logic        inc,
        input logic [10:0] step,
        input logic [10:0] lim
    );
        logic signed [10:0] p;
        logic signed [10:0] r;
        p = $signed({1'b0, pos});
        r = p;
        if (dec) begin
            r = p - $signed(step);
            if (r < 11'sd0) begin
                r = 11'sd0;
            end
        end else if (inc) begin
            r = p + $signed(step);
            if (r > $signed(lim)) begin
                r = $signed(lim);
            end
        end
        return r[9:0];
    endfunction

endpackage

// File: rtl/move_cmd_scheduler_cmd_fifo.sv
// cmd_fifo: small synchronous FIFO (power-of-2 depth, at least 2).
//   clk, rst_n : clock, async active-low reset (empties the queue)
//   push_i     : write wdata_i; accepted when not full, or when full with a
//                pop in the same cycle
//   pop_i      : drop the head entry; ignored when empty
//   rdata_o    : head entry (valid while !empty_o)
//   full_o     : level_o == DEPTH
//   empty_o    : level_o == 0
//   level_o    : exact occupancy 0..DEPTH
module cmd_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot the push needs, so full+pop still accepts.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/move_cmd_scheduler.sv
// move_cmd_scheduler: queues debounced key pulses as direction commands and
// applies at most one per video frame, at vertical-sync start, with clamping
// to the screen edges, so the drawn block never moves mid-frame.
//   clk, rst_n       : system clock, async active-low reset
//   key_up/down/left/right : one-cycle key pulses
//   vga_vs           : vertical sync level from the pixel domain (async)
//   block_x, block_y : block top-left position
//   pos_valid        : one-cycle pulse when block_x/block_y are updated
//   cmd_drop         : one-cycle pulse when a command was lost (queue full)
//   fifo_level       : queue occupancy
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for frame start; pops one queued command if present
// ST_CALC | registers the clamped new position, pulses pos_valid
module move_cmd_scheduler
    import vga_game_pkg::*;
#(
    parameter int   BLK_W      = 40,
    parameter int   BLK_H      = 40,
    parameter int   STEP       = 20,
    parameter int   X0         = 380,
    parameter int   Y0         = 280,
    parameter int   FIFO_DEPTH = 4,
    parameter logic VS_ACT     = 1'b1,
    localparam int  LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_up,
    input  logic             key_down,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             vga_vs,
    output logic [9:0]       block_x,
    output logic [9:0]       block_y,
    output logic             pos_valid,
    output logic             cmd_drop,
    output logic [LVL_W-1:0] fifo_level
);

    logic         vs_s1_q;
    logic         vs_s2_q;
    logic         vs_prev_q;
    logic         frame_start;

    cmd_t         cmd_d;
    logic         has_cmd;
    logic         pop;
    logic         drop_d;
    logic         cmd_drop_q;

    cmd_t         fifo_head;
    logic         fifo_full;
    logic         fifo_empty;
    logic [LVL_W-1:0] fifo_lvl;

    sched_state_t state_q;
    cmd_t         cmd_r_q;
    logic [9:0]   x_q;
    logic [9:0]   y_q;
    logic [9:0]   x_d;
    logic [9:0]   y_d;
    logic         pos_valid_q;

    // vga_vs is asynchronous: two flops for metastability, a third to find
    // the inactive->active transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            vs_s1_q   <= vga_vs;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
        end
    end

    assign frame_start = (vs_s2_q == VS_ACT) && (vs_prev_q != VS_ACT);

    // Opposite keys cancel; orthogonal keys combine into one diagonal move.
    always_comb begin
        cmd_d         = '0;
        cmd_d[CMD_UP] = key_up    & ~key_down;
        cmd_d[CMD_DN] = key_down  & ~key_up;
        cmd_d[CMD_LF] = key_left  & ~key_right;
        cmd_d[CMD_RT] = key_right & ~key_left;
    end

    assign has_cmd = |cmd_d;
    assign pop     = (state_q == ST_IDLE) && frame_start && !fifo_empty;
    assign drop_d  = has_cmd && fifo_full && !pop;

    cmd_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (has_cmd),
        .wdata_i (cmd_d),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_lvl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_drop_q <= 1'b0;
        end else begin
            cmd_drop_q <= drop_d;
        end
    end

    assign x_d = step_clamp(x_q, cmd_r_q[CMD_LF], cmd_r_q[CMD_RT],
                            11'(STEP), 11'(H_ACTIVE - BLK_W));
    assign y_d = step_clamp(y_q, cmd_r_q[CMD_UP], cmd_r_q[CMD_DN],
                            11'(STEP), 11'(V_ACTIVE - BLK_H));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_r_q     <= '0;
            x_q         <= 10'(X0);
            y_q         <= 10'(Y0);
            pos_valid_q <= 1'b0;
        end else begin
            pos_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        cmd_r_q <= fifo_head;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Pulses even when clamping leaves the position unchanged:
                    // the command was still consumed.
                    x_q         <= x_d;
                    y_q         <= y_d;
                    pos_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign block_x    = x_q;
    assign block_y    = y_q;
    assign pos_valid  = pos_valid_q;
    assign cmd_drop   = cmd_drop_q;
    assign fifo_level = fifo_lvl;

endmodule

// File: tb/tb_move_cmd_scheduler.sv
module tb_move_cmd_scheduler;

    localparam logic [3:0] K_UP = 4'b1000;
    localparam logic [3:0] K_DN = 4'b0100;
    localparam logic [3:0] K_LF = 4'b0010;
    localparam logic [3:0] K_RT = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_up = 1'b0;
    logic       key_down = 1'b0;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       vga_vs = 1'b0;
    logic [9:0] block_x;
    logic [9:0] block_y;
    logic       pos_valid;
    logic       cmd_drop;
    logic [2:0] fifo_level;

    move_cmd_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_left   (key_left),
        .key_right  (key_right),
        .vga_vs     (vga_vs),
        .block_x    (block_x),
        .block_y    (block_y),
        .pos_valid  (pos_valid),
        .cmd_drop   (cmd_drop),
        .fifo_level (fifo_level)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int c;
    } exp_t;

    // Reference model: a queue of commands, a home position, and frames that
    // take effect two clocks after vs is driven high (sync + edge register).
    int   mq[$];
    int   frame_q[$];
    exp_t sb[$];
    int   mx = 380;
    int   my = 280;
    int   exp_drops = 0;
    int   act_drops = 0;
    logic vs_prev = 1'b0;
    bit   lvl_req = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void apply_cmd(input int c);
        if (c[3])      my = (my - 20 < 0)   ? 0   : my - 20;
        else if (c[2]) my = (my + 20 > 560) ? 560 : my + 20;
        if (c[1])      mx = (mx - 20 < 0)   ? 0   : mx - 20;
        else if (c[0]) mx = (mx + 20 > 760) ? 760 : mx + 20;
    endfunction

    task automatic step(input logic [3:0] k, input logic v);
        int   c;
        logic [3:0] kk;
        exp_t e;
        @(negedge clk);
        if (lvl_req) begin
            lvl_req = 1'b0;
            check("fifo_level", int'(fifo_level), mq.size());
        end
        {key_up, key_down, key_left, key_right} = k;
        vga_vs = v;
        if (v && !vs_prev) frame_q.push_back(cyc);
        vs_prev = v;
        if (frame_q.size() > 0 && frame_q[0] + 2 == cyc) begin
            void'(frame_q.pop_front());
            if (mq.size() > 0) begin
                c = mq.pop_front();
                apply_cmd(c);
                e.x = mx;
                e.y = my;
                e.c = cyc + 2;
                sb.push_back(e);
            end
        end
        kk = k;
        if (kk[3] && kk[2]) kk[3:2] = 2'b00;
        if (kk[1] && kk[0]) kk[1:0] = 2'b00;
        if (kk != 4'd0) begin
            if (mq.size() < 4) mq.push_back(int'(kk));
            else exp_drops++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'd0, 1'b0);
    endtask

    // vs high for three clocks; keys k land in the cycle the pop happens.
    task automatic frame(input logic [3:0] k);
        step(4'd0, 1'b1);
        step(4'd0, 1'b1);
        step(k, 1'b1);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
    endtask

    task automatic chk_level();
        lvl_req = 1'b1;
        step(4'd0, 1'b0);
    endtask

    task automatic chk_pos(input string nm);
        check({nm, "_x"}, int'(block_x), mx);
        check({nm, "_y"}, int'(block_y), my);
    endtask

    task automatic model_reset();
        mq.delete();
        frame_q.delete();
        sb.delete();
        mx = 380;
        my = 280;
        vs_prev = 1'b0;
        {key_up, key_down, key_left, key_right} = 4'd0;
        vga_vs = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_x", int'(block_x), 380);
        check("rst_y", int'(block_y), 280);
        check("rst_level", int'(fifo_level), 0);
        check("rst_pos_valid", int'(pos_valid), 0);
        check("rst_cmd_drop", int'(cmd_drop), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rnd_keys();
        if ($urandom_range(0, 2) == 0) return 4'($urandom_range(1, 15));
        return 4'd0;
    endfunction

    // Monitor: every pos_valid pops the scoreboard and checks value and timing.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (pos_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pos_valid: got x=%0d y=%0d expected no update (cycle %0d)",
                             block_x, block_y, cyc);
                end else begin
                    e = sb.pop_front();
                    check("pos_x", int'(block_x), e.x);
                    check("pos_y", int'(block_y), e.y);
                    check("pos_latency_cycle", cyc, e.c);
                end
            end
            if (cmd_drop) act_drops++;
        end
    end

    initial begin
        int base_drops;
        int guard;

        // Reset
        repeat (3) @(negedge clk);
        check("init_x", int'(block_x), 380);
        check("init_y", int'(block_y), 280);
        check("init_level", int'(fifo_level), 0);
        check("init_pos_valid", int'(pos_valid), 0);
        rst_n = 1'b1;
        idle(3);

        // 1: single right move
        step(K_RT, 1'b0);
        chk_level();
        frame(4'd0);
        check("t1_x", int'(block_x), 400);
        check("t1_y", int'(block_y), 280);

        // 2: three lefts, one applied per frame
        repeat (3) step(K_LF, 1'b0);
        chk_level();
        frame(4'd0);
        check("t2_x1", int'(block_x), 380);
        chk_level();
        frame(4'd0);
        check("t2_x2", int'(block_x), 360);
        chk_level();
        frame(4'd0);
        check("t2_x3", int'(block_x), 340);
        chk_level();
        frame(4'd0);
        chk_level();
        chk_pos("t2_empty_frame");

        // 3: clamping at right and top edges
        guard = 0;
        while (mx < 760 && guard < 60) begin
            step(K_RT, 1'b0);
            frame(4'd0);
            guard++;
        end
        check("t3_right_edge", int'(block_x), 760);
        step(K_RT, 1'b0);
        frame(4'd0);
        check("t3_right_clamp", int'(block_x), 760);
        guard = 0;
        while (my > 0 && guard < 60) begin
            step(K_UP, 1'b0);
            frame(4'd0);
            guard++;
        end
        check("t3_top_edge", int'(block_y), 0);
        step(K_UP, 1'b0);
        frame(4'd0);
        check("t3_top_clamp", int'(block_y), 0);

        // 4: cancel and diagonal
        do_reset();
        idle(2);
        step(K_UP | K_DN, 1'b0);
        step(K_LF | K_RT, 1'b0);
        chk_level();
        check("t4_cancel_level", int'(fifo_level), 0);
        step(K_UP | K_LF, 1'b0);
        chk_level();
        frame(4'd0);
        check("t4_diag_x", int'(block_x), 360);
        check("t4_diag_y", int'(block_y), 260);

        // 5: overflow, then push coinciding with a pop while full
        base_drops = act_drops;
        step(K_RT, 1'b0);
        step(K_DN, 1'b0);
        step(K_LF, 1'b0);
        step(K_UP, 1'b0);
        step(K_RT, 1'b0);
        step(K_DN, 1'b0);
        chk_level();
        check("t5_full_level", int'(fifo_level), 4);
        idle(2);
        check("t5_drops", act_drops - base_drops, 2);
        check("t5_drops_model", act_drops, exp_drops);
        frame(K_RT | K_DN);
        chk_level();
        check("t5_push_pop_level", int'(fifo_level), 4);
        check("t5_no_extra_drop", act_drops - base_drops, 2);
        repeat (4) frame(4'd0);
        chk_level();
        chk_pos("t5_drained");

        // 6: reset while in CALC
        step(K_LF, 1'b0);
        step(4'd0, 1'b1);
        step(4'd0, 1'b1);
        step(4'd0, 1'b1);
        do_reset();
        idle(3);
        frame(4'd0);
        frame(4'd0);
        chk_level();
        check("t6_x", int'(block_x), 380);
        check("t6_y", int'(block_y), 280);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(2, 10)) step(rnd_keys(), 1'b0);
            step(rnd_keys(), 1'b1);
            step(rnd_keys(), 1'b1);
            step(rnd_keys(), 1'b1);
            step(rnd_keys(), 1'b0);
            step(rnd_keys(), 1'b0);
        end
        idle(8);
        chk_level();
        chk_pos("rand_final");
        check("rand_drops", act_drops, exp_drops);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
